// File: rtl/or_8bit_pkg.sv
// Shared definitions for the 8-bit ALU logic units (or/and/xor/not).
package or_8bit_pkg;

  // Datapath width of the 8-bit ALU.
  localparam int unsigned ALU_WIDTH = 8;

  // Status flags produced by every logic unit for the ALU flag logic.
  typedef struct packed {
    logic zero;      // result == 0
    logic all_ones;  // result == all ones
    logic parity;    // XOR-reduction of result, 1 = odd number of ones
  } alu_flags_t;

  // Flag values that correspond to a cleared (all-zero) result.
  localparam alu_flags_t FLAGS_RESET = '{zero: 1'b1, all_ones: 1'b0, parity: 1'b0};

endpackage

// File: rtl/or_8bit_logic_flags.sv
// Combinational zero / all-ones / parity flags of a WIDTH-bit value.
// Shared by the ALU logic units so that every unit reports flags identically.
module or_8bit_logic_flags
  import or_8bit_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] value_i,
  output alu_flags_t       flags_o
);

  // Reduce the value to its three status flags.
  always_comb begin
    flags_o          = FLAGS_RESET;
    flags_o.zero     = ~|value_i;
    flags_o.all_ones = &value_i;
    flags_o.parity   = ^value_i;
  end

endmodule

// File: rtl/or_8bit.sv
// Registered bitwise-OR unit for the 8-bit ALU datapath.
// One-cycle latency, one result per cycle, no backpressure. Result and flags are
// captured together from the same operand pair so they can never disagree.
module or_8bit
  import or_8bit_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             zero,
  output logic             all_ones,
  output logic             parity
);

  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] result_q;
  alu_flags_t       flags_d;
  alu_flags_t       flags_q;
  logic             valid_q;

  // Bitwise OR of the operands; no carries, no width growth.
  always_comb begin
    result_d = a | b;
  end

  or_8bit_logic_flags #(
    .WIDTH (WIDTH)
  ) u_flags (
    .value_i (result_d),
    .flags_o (flags_d)
  );

  // Capture result and flags only on accepted operands, so undefined operands
  // presented with in_valid low never reach the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= FLAGS_RESET;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        result_q <= result_d;
        flags_q  <= flags_d;
      end
    end
  end

  // Drive the ports straight from the registers.
  always_comb begin
    out       = result_q;
    out_valid = valid_q;
    zero      = flags_q.zero;
    all_ones  = flags_q.all_ones;
    parity    = flags_q.parity;
  end

endmodule

// File: tb/tb_or_8bit.sv
// Self-checking bench for or_8bit: directed cases followed by random operands,
// compared against a behavioural model of the unit kept here.
module tb_or_8bit;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] out;
  logic         out_valid;
  logic         zero;
  logic         all_ones;
  logic         parity;

  int n_vec = 0;
  int n_err = 0;
  int n_chk = 0;

  // Model state: last registered result and whether it is fresh this cycle.
  logic [W-1:0] m_out;
  logic         m_valid;

  or_8bit #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out       (out),
    .out_valid (out_valid),
    .zero      (zero),
    .all_ones  (all_ones),
    .parity    (parity)
  );

  always #5 clk = ~clk;

  // Parity by counting ones.
  function automatic logic ref_parity(input logic [W-1:0] v);
    int ones = 0;
    for (int i = 0; i < W; i++) begin
      if (v[i]) ones++;
    end
    return (ones % 2) == 1;
  endfunction

  task automatic model_reset();
    m_out   = '0;
    m_valid = 1'b0;
  endtask

  // Compare every output against the model.
  task automatic check_all(input string tag);
    logic exp_zero;
    logic exp_ones;
    logic exp_par;
    exp_zero = (m_out == 0);
    exp_ones = (m_out == {W{1'b1}});
    exp_par  = ref_parity(m_out);
    n_chk += 5;
    assert (out === m_out) else begin
      n_err++;
      $error("FAIL %s out: observed %h expected %h", tag, out, m_out);
    end
    assert (out_valid === m_valid) else begin
      n_err++;
      $error("FAIL %s out_valid: observed %b expected %b", tag, out_valid, m_valid);
    end
    assert (zero === exp_zero) else begin
      n_err++;
      $error("FAIL %s zero: observed %b expected %b", tag, zero, exp_zero);
    end
    assert (all_ones === exp_ones) else begin
      n_err++;
      $error("FAIL %s all_ones: observed %b expected %b", tag, all_ones, exp_ones);
    end
    assert (parity === exp_par) else begin
      n_err++;
      $error("FAIL %s parity: observed %b expected %b", tag, parity, exp_par);
    end
  endtask

  // Direct check of the result against a hand-computed constant.
  task automatic check_out(input string tag, input logic [W-1:0] exp);
    n_chk++;
    assert (out === exp) else begin
      n_err++;
      $error("FAIL %s const: observed %h expected %h", tag, out, exp);
    end
  endtask

  // Drive one operand pair at the falling edge, then check 1 time unit after the
  // capturing rising edge.
  task automatic apply(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input string tag);
    @(negedge clk);
    in_valid = v;
    a        = av;
    b        = bv;
    @(posedge clk);
    if (v) begin
      m_out   = av | bv;
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    n_vec++;
    #1 check_all(tag);
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    model_reset();

    // Asynchronous reset between clock edges.
    #1 rst = 1'b1;
    #2 check_all("por_async");
    repeat (2) @(posedge clk);
    #1 check_all("por_held");
    @(negedge clk) rst = 1'b0;

    // Zero and identity on consecutive edges.
    apply(1'b1, 8'h00, 8'h00, "zero");
    check_out("zero", 8'h00);
    apply(1'b1, 8'h00, 8'hD3, "ident");
    check_out("ident", 8'hD3);

    // Saturation.
    apply(1'b1, 8'hFF, 8'h00, "sat_a");
    check_out("sat_a", 8'hFF);
    apply(1'b1, 8'hFF, 8'hFF, "sat_ab");
    check_out("sat_ab", 8'hFF);

    // Mixed patterns.
    apply(1'b1, 8'hAA, 8'hCC, "mix");
    check_out("mix", 8'hEE);
    apply(1'b1, 8'hEC, 8'h13, "compl");
    check_out("compl", 8'hFF);

    // Hold behaviour, including undefined operands while idle.
    apply(1'b1, 8'h00, 8'hD3, "pre_hold");
    apply(1'b0, 8'h55, 8'hAA, "hold");
    check_out("hold", 8'hD3);
    apply(1'b0, 'x, 'x, "hold_x");
    check_out("hold_x", 8'hD3);

    // Mid-stream reset.
    apply(1'b1, 8'h0F, 8'hF0, "stream0");
    apply(1'b1, 8'h0F, 8'hF0, "stream1");
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all("mid_rst_async");
    @(posedge clk);
    #1 check_all("mid_rst_held");
    @(negedge clk) rst = 1'b0;
    in_valid = 1'b0;
    apply(1'b1, 8'h01, 8'h02, "post_rst");
    check_out("post_rst", 8'h03);

    // Random operands with random gaps in in_valid.
    for (int i = 0; i < 300; i++) begin
      logic         rv;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      rv = ($urandom_range(0, 3) != 0);
      ra = W'($urandom);
      rb = W'($urandom);
      apply(rv, ra, rb, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
